// File: rtl/cpu_decode_stage.sv
// cpu_decode_stage: registered RV32I decode stage between fetch and execute.
// Each accepted instruction is split into its fields and classified by format.
// A sign-extended immediate is formed. Results are held in a main register (M)
// backed by a one-entry skid register (S). Because of S, the upstream ready is
// a pure flop output.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_flush             drop everything held; blocks acceptance this cycle
//   i_valid/o_ready     upstream handshake (o_ready registered)
//   i_inst, i_pc        instruction word and its address
//   o_valid/i_ready     downstream handshake
//   o_pc, o_op, o_rd, o_rs1, o_rs2, o_func, o_fmt, o_imm, o_illegal
//                       decoded fields (o_fmt: 0=R 1=I 2=S 3=B 4=U 5=J 7=invalid)
//   o_illegal_cnt       saturating count of illegal beats taken downstream.
//                       This port exists only when CPU_DECODE_STAGE_ILLEGAL_CNT_EN
//                       is defined.
module cpu_decode_stage #(
    parameter int unsigned IMM_W = 32,
    parameter int unsigned PC_W  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [PC_W-1:0]  i_pc,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [PC_W-1:0]  o_pc,
    output logic [6:0]       o_op,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic [9:0]       o_func,
    output logic [2:0]       o_fmt,
    output logic [IMM_W-1:0] o_imm,
    output logic             o_illegal
`ifdef CPU_DECODE_STAGE_ILLEGAL_CNT_EN
    ,
    output logic [15:0]      o_illegal_cnt
`endif
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_INV = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [6:0]       op;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [9:0]       func;
        fmt_e             fmt;
        logic [IMM_W-1:0] imm;
        logic             illegal;
    } beat_t;

    localparam beat_t EMPTY = '{pc: '0, op: '0, rd: '0, rs1: '0, rs2: '0,
                                func: '0, fmt: FMT_INV, imm: '0, illegal: 1'b0};

    // ---------------- combinational decode of the incoming word ----------------
    beat_t       dec;
    fmt_e        fmt;
    logic [31:0] imm32;
    logic [63:0] imm64;

    always_comb begin
        unique case (i_inst[6:0])
            7'b0110111, 7'b0010111:                         fmt = FMT_U;
            7'b1101111:                                     fmt = FMT_J;
            7'b1100011:                                     fmt = FMT_B;
            7'b0100011:                                     fmt = FMT_S;
            7'b0110011:                                     fmt = FMT_R;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011:                         fmt = FMT_I;
            default:                                        fmt = FMT_INV;
        endcase
        if (i_inst[1:0] != 2'b11) fmt = FMT_INV;

        unique case (fmt)
            FMT_I:   imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            FMT_S:   imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            FMT_B:   imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                              i_inst[30:25], i_inst[11:8], 1'b0};
            FMT_U:   imm32 = {i_inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                              i_inst[20], i_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Extend to 64 bits first so one slice serves every IMM_W from 21 to 64.
        imm64 = {{32{imm32[31]}}, imm32};

        dec         = EMPTY;
        dec.pc      = i_pc;
        dec.op      = i_inst[6:0];
        dec.func    = {i_inst[31:25], i_inst[14:12]};
        dec.fmt     = fmt;
        dec.imm     = imm64[IMM_W-1:0];
        dec.illegal = (fmt == FMT_INV);
        dec.rd      = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : i_inst[11:7];
        dec.rs1     = (fmt == FMT_U || fmt == FMT_J) ? 5'd0 : i_inst[19:15];
        dec.rs2     = (fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) ? 5'd0
                                                                     : i_inst[24:20];
    end

    // ---------------- M/S skid buffer ----------------
    logic  m_valid_q, m_valid_d;
    logic  s_valid_q, s_valid_d;
    logic  ready_q, ready_d;
    beat_t m_q, m_d;
    beat_t s_q, s_d;
    logic  in_fire, out_fire;

    assign in_fire  = i_valid && ready_q && !i_flush;
    assign out_fire = m_valid_q && i_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_d       = m_q;
        s_d       = s_q;
        if (i_flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_d       = EMPTY;
            s_d       = EMPTY;
        end else if (out_fire || !m_valid_q) begin
            // M is free this edge. S is older than any new beat, so S goes
            // first. in_fire cannot occur while S is full because ready_q is low.
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_d       = s_q;
                s_valid_d = 1'b0;
                s_d       = EMPTY;
            end else if (in_fire) begin
                m_valid_d = 1'b1;
                m_d       = dec;
            end else begin
                m_valid_d = 1'b0;
                m_d       = EMPTY;
            end
        end else if (in_fire) begin
            s_valid_d = 1'b1;
            s_d       = dec;
        end
        ready_d = !s_valid_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            ready_q   <= 1'b1;
            m_q       <= EMPTY;
            s_q       <= EMPTY;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            ready_q   <= ready_d;
            m_q       <= m_d;
            s_q       <= s_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = m_valid_q;
    assign o_pc      = m_q.pc;
    assign o_op      = m_q.op;
    assign o_rd      = m_q.rd;
    assign o_rs1     = m_q.rs1;
    assign o_rs2     = m_q.rs2;
    assign o_func    = m_q.func;
    assign o_fmt     = m_q.fmt;
    assign o_imm     = m_q.imm;
    assign o_illegal = m_q.illegal;

`ifdef CPU_DECODE_STAGE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    // A beat taken on the same edge as a flush is discarded, so it is not counted.
    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (out_fire && m_q.illegal && !i_flush && illegal_cnt_q != 16'hFFFF)
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) illegal_cnt_q <= '0;
        else          illegal_cnt_q <= illegal_cnt_d;
    end

    assign o_illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_decode_stage.sv
module tb_cpu_decode_stage;
    localparam int unsigned IMM_W = 32;
    localparam int unsigned PC_W  = 32;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [31:0]      i_inst = '0;
    logic [PC_W-1:0]  i_pc = '0;
    logic             o_valid;
    logic             i_ready = 1'b0;
    logic [PC_W-1:0]  o_pc;
    logic [6:0]       o_op;
    logic [4:0]       o_rd, o_rs1, o_rs2;
    logic [9:0]       o_func;
    logic [2:0]       o_fmt;
    logic [IMM_W-1:0] o_imm;
    logic             o_illegal;
`ifdef CPU_DECODE_STAGE_ILLEGAL_CNT_EN
    logic [15:0]      o_illegal_cnt;
`endif

    cpu_decode_stage #(.IMM_W(IMM_W), .PC_W(PC_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_inst(i_inst), .i_pc(i_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_op(o_op),
        .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_func(o_func),
        .o_fmt(o_fmt), .o_imm(o_imm), .o_illegal(o_illegal)
`ifdef CPU_DECODE_STAGE_ILLEGAL_CNT_EN
        , .o_illegal_cnt(o_illegal_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [9:0]  func;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int unsigned cnt_m = 0;
    logic [6:0] ops [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sext(input longint v, input int n);
        longint lim;
        lim = longint'(1) << (n - 1);
        return (v >= lim) ? v - (lim << 1) : v;
    endfunction

    // Reference decode: field values computed arithmetically from the word.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t   e;
        longint u, imm;
        u = longint'({32'd0, inst});
        case (u & 'h7F)
            'h37, 'h17:                    e.fmt = 3'd4;
            'h6F:                          e.fmt = 3'd5;
            'h63:                          e.fmt = 3'd3;
            'h23:                          e.fmt = 3'd2;
            'h33:                          e.fmt = 3'd0;
            'h67, 'h03, 'h13, 'h0F, 'h73:  e.fmt = 3'd1;
            default:                       e.fmt = 3'd7;
        endcase
        if ((u & 3) != 3) e.fmt = 3'd7;
        case (e.fmt)
            3'd1: imm = sext((u >> 20) & 'hFFF, 12);
            3'd2: imm = sext(((u >> 25) << 5) | ((u >> 7) & 'h1F), 12);
            3'd3: imm = sext((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                             (((u >> 25) & 'h3F) << 5) | (((u >> 8) & 'hF) << 1), 13);
            3'd4: imm = sext(u & 'hFFFFF000, 32);
            3'd5: imm = sext((((u >> 31) & 1) << 20) | (((u >> 12) & 'hFF) << 12) |
                             (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3FF) << 1), 21);
            default: imm = 0;
        endcase
        e.imm     = 32'(imm);
        e.pc      = pc;
        e.op      = 7'(u & 'h7F);
        e.func    = 10'((((u >> 25) & 'h7F) * 8) + ((u >> 12) & 7));
        e.rd      = (e.fmt == 3'd2 || e.fmt == 3'd3) ? 5'd0 : 5'((u >> 7) & 31);
        e.rs1     = (e.fmt == 3'd4 || e.fmt == 3'd5) ? 5'd0 : 5'((u >> 15) & 31);
        e.rs2     = (e.fmt == 3'd1 || e.fmt == 3'd4 || e.fmt == 3'd5) ? 5'd0
                                                                      : 5'((u >> 20) & 31);
        e.illegal = (e.fmt == 3'd7);
        return e;
    endfunction

    task automatic check_out(input exp_t e);
        chk("o_pc", 64'(o_pc), 64'(e.pc));
        chk("o_op", 64'(o_op), 64'(e.op));
        chk("o_rd", 64'(o_rd), 64'(e.rd));
        chk("o_rs1", 64'(o_rs1), 64'(e.rs1));
        chk("o_rs2", 64'(o_rs2), 64'(e.rs2));
        chk("o_func", 64'(o_func), 64'(e.func));
        chk("o_fmt", 64'(o_fmt), 64'(e.fmt));
        chk("o_imm", 64'(o_imm), 64'(e.imm));
        chk("o_illegal", 64'(o_illegal), 64'(e.illegal));
    endtask

    // One clock: drive inputs, advance the 2-deep FIFO model, then check.
    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic rdy, input logic fl, output bit acc, output bit popped);
        i_valid = v; i_inst = inst; i_pc = pc; i_ready = rdy; i_flush = fl;
        acc    = v && (q.size() < 2) && !fl;
        popped = (q.size() > 0) && rdy && !fl;
        if (popped && q[0].illegal && cnt_m != 16'hFFFF) cnt_m++;
        @(posedge i_clk);
        #1;
        if (fl) q.delete();
        else begin
            if (popped) void'(q.pop_front());
            if (acc) q.push_back(model(inst, pc));
        end
        chk("o_valid", 64'(o_valid), 64'(q.size() > 0));
        chk("o_ready", 64'(o_ready), 64'(q.size() < 2));
        if (q.size() > 0) check_out(q[0]);
`ifdef CPU_DECODE_STAGE_ILLEGAL_CNT_EN
        chk("o_illegal_cnt", 64'(o_illegal_cnt), 64'(cnt_m));
`endif
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [4:0]  rd, rs1, rs2;
        logic [9:0]  func;
        logic [31:0] imm;
        logic        illegal;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit a, p;
        int k, emitted, guard;
        logic [31:0] stream [8];

        ops = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h33,
                7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h7F};

        vecs[0] = '{32'h00500093, 3'd1, 5'd1, 5'd0, 5'd0, 10'h000, 32'h00000005, 1'b0};
        vecs[1] = '{32'hFE000EE3, 3'd3, 5'd0, 5'd0, 5'd0, 10'h3F8, 32'hFFFFFFFC, 1'b0};
        vecs[2] = '{32'h123450B7, 3'd4, 5'd1, 5'd0, 5'd0, 10'h04D, 32'h12345000, 1'b0};
        vecs[3] = '{32'hFFDFF06F, 3'd5, 5'd0, 5'd0, 5'd0, 10'h3FF, 32'hFFFFFFFC, 1'b0};
        vecs[4] = '{32'h0000007F, 3'd7, 5'd0, 5'd0, 5'd0, 10'h000, 32'h00000000, 1'b1};
        vecs[5] = '{32'h00000001, 3'd7, 5'd0, 5'd0, 5'd0, 10'h000, 32'h00000000, 1'b1};

        // Reset state
        #12;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
        chk("rst_o_fmt", 64'(o_fmt), 64'd7);
        chk("rst_o_imm", 64'(o_imm), 64'd0);
        chk("rst_o_pc", 64'(o_pc), 64'd0);
        chk("rst_o_illegal", 64'(o_illegal), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed decode vectors
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vecs[i].inst, 32'h1000 + 32'(4 * i), 1'b1, 1'b0, a, p);
            chk("vec_valid", 64'(o_valid), 64'd1);
            chk("vec_pc", 64'(o_pc), 64'(32'h1000 + 32'(4 * i)));
            chk("vec_fmt", 64'(o_fmt), 64'(vecs[i].fmt));
            chk("vec_rd", 64'(o_rd), 64'(vecs[i].rd));
            chk("vec_rs1", 64'(o_rs1), 64'(vecs[i].rs1));
            chk("vec_rs2", 64'(o_rs2), 64'(vecs[i].rs2));
            chk("vec_func", 64'(o_func), 64'(vecs[i].func));
            chk("vec_imm", 64'(o_imm), 64'(vecs[i].imm));
            chk("vec_illegal", 64'(o_illegal), 64'(vecs[i].illegal));
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a, p);
`ifdef CPU_DECODE_STAGE_ILLEGAL_CNT_EN
        chk("cnt_after_two_illegal", 64'(o_illegal_cnt), 64'd2);
`endif

        // 8-instruction stream with a 3-cycle downstream stall
        for (int i = 0; i < 8; i++) stream[i] = rand_inst();
        k = 0; emitted = 0; guard = 0;
        while ((k < 8 || q.size() > 0) && guard < 40) begin
            step(k < 8, (k < 8) ? stream[k] : 32'h0, 32'h2000 + 32'(4 * k),
                 !(guard >= 3 && guard < 6), 1'b0, a, p);
            k += int'(a);
            emitted += int'(p);
            guard++;
        end
        chk("stream_done_in_budget", 64'(guard < 40), 64'd1);
        chk("stream_emitted", 64'(emitted), 64'd8);

        // Flush with M and S full and a new beat offered
        step(1'b1, 32'h00100113, 32'h3000, 1'b0, 1'b0, a, p);
        step(1'b1, 32'h00200193, 32'h3004, 1'b0, 1'b0, a, p);
        chk("full_before_flush", 64'(o_ready), 64'd0);
        step(1'b1, 32'h00300213, 32'h3008, 1'b1, 1'b1, a, p);
        chk("flush_valid", 64'(o_valid), 64'd0);
        chk("flush_ready", 64'(o_ready), 64'd1);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a, p);
        chk("flush_beat_absent", 64'(o_valid), 64'd0);

        // Asynchronous reset while stalled with both entries full
        step(1'b1, 32'h00100113, 32'h4000, 1'b0, 1'b0, a, p);
        step(1'b1, 32'h00200193, 32'h4004, 1'b0, 1'b0, a, p);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, a, p);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'd0);
        chk("async_rst_ready", 64'(o_ready), 64'd1);
        chk("async_rst_fmt", 64'(o_fmt), 64'd7);
        q.delete();
        cnt_m = 0;
        #2;
        i_rst_n = 1'b1;

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, a, p);

`ifdef CPU_DECODE_STAGE_ILLEGAL_CNT_EN
        for (int i = 0; i < 65540; i++)
            step(1'b1, 32'h0000007F, 32'h0, 1'b1, 1'b0, a, p);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, a, p);
        chk("cnt_saturated", 64'(o_illegal_cnt), 64'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_decode_stage.md
Name: cpu_decode_stage

Overview:
- Registered, back-pressurable instruction decode stage between fetch and execute.
- Splits each 32-bit RV32I instruction into fields and classifies its format.
- Produces a fully formed, sign-extended immediate of parametrised width.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so the upstream ready is a pure register output. Carries the PC and supports flush.

Parameters:
IMM_W, 32, width of sign-extended immediate output (legal range 21..64).
PC_W, 32, width of PC sideband carried with each instruction.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  discard all held/in-flight instructions
i_valid  input  1  upstream instruction valid
o_ready  output  1  stage can accept (registered)
i_inst  input  32  instruction word
i_pc  input  PC_W  instruction address
o_valid  output  1  decoded instruction valid
i_ready  input  1  downstream accepts
o_pc  output  PC_W  PC of decoded instruction
o_op  output  7  inst[6:0]
o_rd  output  5  inst[11:7]; 0 for S/B formats
o_rs1  output  5  inst[19:15]; 0 for U/J formats
o_rs2  output  5  inst[24:20]; 0 for I/U/J formats
o_func  output  10  {inst[31:25], inst[14:12]}
o_fmt  output  3  0=R 1=I 2=S 3=B 4=U 5=J 7=invalid
o_imm  output  IMM_W  sign-extended immediate
o_illegal  output  1  instruction not decodable

Behaviour:
- Reset: o_valid=0, o_ready=1, skid empty. All data outputs 0; o_fmt=7.
- Handshake: a transfer occurs when valid&&ready on the same edge. Decoded output appears one cycle after input acceptance.
- o_valid holds and data outputs stay stable while o_valid && !i_ready.
- Skid buffer:
  - Main register M drives the outputs. Skid register S catches the accepted beat when M is valid and stalled.
  - o_ready = !S_full, registered.
  - On downstream accept, S moves into M the same edge, else M loads the new beat or clears.
  - Order is strictly FIFO. Never more than 2 beats held. Accepting while S is full is impossible by construction.
- Simultaneous accept-in and accept-out with S empty: M replaced by new beat, no bubble. Sustains 1 instr/cycle.
- Decode is combinational on the input word, registered into M/S, so there is no decode logic on the output path.
- Format by opcode:
  - 0110111/0010111 -> U
  - 1101111 -> J
  - 1100011 -> B
  - 0100011 -> S
  - 0110011 -> R
  - 1100111/0000011/0010011/0001111/1110011 -> I
  - anything else -> invalid
- Immediate (byte offsets, sign bit inst[31], extended to IMM_W):
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - R and invalid: 0
- o_illegal = (fmt==invalid) || inst[1:0]!=2'b11. If inst[1:0]!=2'b11, force o_fmt=7, o_imm=0.
- Illegal instructions still flow through the handshake (o_valid=1) so execute can trap; they are never dropped.
- Flush:
  - i_flush=1 at an edge clears M and S: o_valid=0 and o_ready=1 next cycle.
  - An i_valid beat presented in the same cycle is not accepted, even if o_ready=1.
  - Flush has priority over all handshakes.
- Reset mid-operation: immediate async clear to the reset values, regardless of handshake state.

Optional Feature:
CPU_DECODE_STAGE_ILLEGAL_CNT_EN
- Defined:
  - Adds output port o_illegal_cnt, 16 bits, reset 0.
  - Increments when a beat with o_illegal=1 is accepted downstream (o_valid&&i_ready&&o_illegal). Saturates at 16'hFFFF.
  - Flushed beats are not counted. Unaffected by i_flush.
- Undefined: port and counter absent, all other behaviour identical.

Test Plan:
- Reset, then present 32'h00500093 (addi x1,x0,5) with i_ready=1 -> next cycle o_valid=1, o_fmt=1, o_rd=1, o_rs1=0, o_rs2=0, o_imm=5, o_illegal=0, o_pc=i_pc.
- Immediate/sign extension (IMM_W=32):
  - 32'hFE000EE3 (beq, offset -4) -> o_fmt=3, o_imm=32'hFFFFFFFC, o_rd=0.
  - 32'h123450B7 (lui) -> o_fmt=4, o_imm=32'h12345000.
  - 32'hFFDFF06F (jal -4) -> o_fmt=5, o_imm=32'hFFFFFFFC.
- Back-to-back stream of 8 instrs, i_ready held 0 for 3 cycles mid-stream -> o_ready drops exactly after 2 beats are held, output stable while stalled, all 8 emerge in order with no loss or duplication, 1/cycle after release.
- Illegal: 32'h0000007F and 32'h00000001 -> o_valid=1, o_illegal=1, o_fmt=7, o_imm=0. With CPU_DECODE_STAGE_ILLEGAL_CNT_EN: o_illegal_cnt reaches 2 after both are accepted; preloaded at 16'hFFFF it stays 16'hFFFF.
- Flush with M and S full and i_valid=1 in the same cycle -> next cycle o_valid=0, o_ready=1, incoming beat absent from the output.
- Assert i_rst_n=0 asynchronously mid-stall -> o_valid=0 and o_ready=1 without waiting for a clock edge.
